// File: rtl/trace_pkg.sv
// Shared types for the instruction-trace streamer: FSM states, header layout
// and the packed per-instruction record held in the FIFO.
package trace_pkg;

  typedef enum logic [2:0] {IDLE, HDR, PC, INSTR, ADDR} state_t;

  localparam int HDR_SEQ_LSB    = 16;
  localparam int HDR_REG_WE_BIT = 15;
  localparam int HDR_DM_EN_BIT  = 14;
  localparam int HDR_WADDR_LSB  = 9;
  localparam int HDR_OVF_BIT    = 8;

  typedef struct packed {
    logic [15:0] seq;
    logic        reg_we;
    logic        dm_en;
    logic [4:0]  reg_waddr;
    logic        ovf;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] dm_addr;
  } record_t;

  function automatic logic [31:0] header_word(record_t r);
    logic [31:0] w;
    w = '0;
    w[HDR_SEQ_LSB +: 16]  = r.seq;
    w[HDR_REG_WE_BIT]     = r.reg_we;
    w[HDR_DM_EN_BIT]      = r.dm_en;
    w[HDR_WADDR_LSB +: 5] = r.reg_waddr;
    w[HDR_OVF_BIT]        = r.ovf;
    return w;
  endfunction

  // Word presented on the link while the FSM sits in state s.
  function automatic logic [31:0] stream_word(state_t s, record_t r);
    case (s)
      HDR:     return header_word(r);
      PC:      return r.pc;
      INSTR:   return r.instr;
      ADDR:    return r.dm_en ? r.dm_addr : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Register FIFO of trace records; exposes the head and the entry behind it
// so the streamer can present the next header without a bubble.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  logic    pop,
  input  record_t din,
  output record_t dout,
  output record_t dout_next,
  output logic    full,
  output logic    empty,
  output logic    single
);

  localparam int AW = $clog2(DEPTH);

  record_t       mem [DEPTH];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic [AW:0]   rptr_inc;
  logic [AW:0]   count;

  assign rptr_inc  = rptr + 1'b1;
  assign count     = wptr - rptr;
  assign empty     = (wptr == rptr);
  assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign single    = (count == {{AW{1'b0}}, 1'b1});
  assign dout      = mem[rptr[AW-1:0]];
  assign dout_next = mem[rptr_inc[AW-1:0]];

  // NOTE: storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr_inc;
    end
  end

endmodule

// File: rtl/trace_streamer.sv
// Captures one record per retired instruction and streams it as four
// 32-bit words (HDR, PC, INSTR, ADDR) over a valid/ready link.
module trace_streamer
  import trace_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        retire,
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic        reg_we,
  input  logic [4:0]  reg_waddr,
  input  logic        dm_en,
  input  logic [31:0] dm_addr,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_last,
  output logic [7:0]  drop_count
);

  state_t      state, state_nx;
  logic [15:0] seq;
  logic        ovf_pending;
  record_t     rec_in, head, head_next, next_rec;
  logic        full, empty, single;
  logic        accept, pop, push, drop;
  logic [31:0] tx_data_nx;
  logic        tx_valid_nx, tx_last_nx;

  assign accept = tx_valid && tx_ready;
  assign pop    = accept && (state == ADDR);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push   = retire && (!full || pop);
  assign drop   = retire && full && !pop;

  assign rec_in = '{seq: seq, reg_we: reg_we, dm_en: dm_en, reg_waddr: reg_waddr,
                    ovf: ovf_pending, pc: pc, instr: instr, dm_addr: dm_addr};

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .din       (rec_in),
    .dout      (head),
    .dout_next (head_next),
    .full      (full),
    .empty     (empty),
    .single    (single)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nx = state;
    next_rec = head;
    unique case (state)
      IDLE:  if (!empty) state_nx = HDR;
      HDR:   if (accept) state_nx = PC;
      PC:    if (accept) state_nx = INSTR;
      INSTR: if (accept) state_nx = ADDR;
      ADDR: begin
        if (accept) begin
          if (!single) begin
            state_nx = HDR;
            next_rec = head_next;
          end else if (push) begin
            state_nx = HDR;
            next_rec = rec_in;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    // Head is stable while a record streams, so an unaccepted word recomputes to itself.
    tx_valid_nx = (state_nx != IDLE);
    tx_last_nx  = (state_nx == ADDR);
    tx_data_nx  = stream_word(state_nx, next_rec);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      tx_last     <= 1'b0;
      seq         <= '0;
      ovf_pending <= 1'b0;
      drop_count  <= '0;
    end else begin
      state    <= state_nx;
      tx_data  <= tx_data_nx;
      tx_valid <= tx_valid_nx;
      tx_last  <= tx_last_nx;
      if (retire) seq <= seq + 16'd1;
      if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      if (drop)      ovf_pending <= 1'b1;
      else if (push) ovf_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_trace_streamer.sv
// Directed bench for trace_streamer: vector table of single records plus
// hand-written backpressure, overflow, full-pop-push, reset and wrap sequences.
module tb_trace_streamer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        retire;
  logic [31:0] pc, instr, dm_addr;
  logic        reg_we, dm_en;
  logic [4:0]  reg_waddr;
  logic [31:0] tx_data;
  logic        tx_valid, tx_ready, tx_last;
  logic [7:0]  drop_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] dm_addr;
    logic        reg_we;
    logic        dm_en;
    logic [4:0]  waddr;
    logic [31:0] exp_hdr;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[4];

  always #5 clk = ~clk;

  trace_streamer #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .retire     (retire),
    .pc         (pc),
    .instr      (instr),
    .reg_we     (reg_we),
    .reg_waddr  (reg_waddr),
    .dm_en      (dm_en),
    .dm_addr    (dm_addr),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_last    (tx_last),
    .drop_count (drop_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_retire(input logic [31:0] p, input logic [31:0] i, input logic [31:0] a,
                            input logic we, input logic en, input logic [4:0] wa);
    retire = 1'b1; pc = p; instr = i; dm_addr = a;
    reg_we = we; dm_en = en; reg_waddr = wa;
  endtask

  task automatic do_retire(input logic [31:0] p, input logic [31:0] i, input logic [31:0] a,
                           input logic we, input logic en, input logic [4:0] wa);
    set_retire(p, i, a, we, en, wa);
    tick();
    retire = 1'b0;
  endtask

  // Checks the presented word, then lets it be accepted (tx_ready held at 1).
  task automatic expect_word(input string name, input logic [31:0] exp, input logic last);
    check({name, " valid"}, {31'b0, tx_valid}, 32'd1);
    check({name, " data"}, tx_data, exp);
    check({name, " last"}, {31'b0, tx_last}, {31'b0, last});
    tick();
  endtask

  task automatic check_record(input string name, input logic [31:0] hdr, input logic [31:0] p,
                              input logic [31:0] i, input logic [31:0] a, output int waits);
    tx_ready = 1'b1;
    waits = 0;
    while (!tx_valid && waits < 10) begin
      tick();
      waits++;
    end
    if (!tx_valid) begin
      check({name, " timeout"}, {31'b0, tx_valid}, 32'd1);
      return;
    end
    expect_word({name, " hdr"}, hdr, 1'b0);
    expect_word({name, " pc"}, p, 1'b0);
    expect_word({name, " instr"}, i, 1'b0);
    expect_word({name, " addr"}, a, 1'b1);
  endtask

  initial begin
    int w;

    vecs[0] = '{32'h0040_0000, 32'h2002_0005, 32'h0000_0000, 1'b1, 1'b0, 5'd2,  32'h0000_8400, 32'h0000_0000};
    vecs[1] = '{32'h0040_0004, 32'hAC08_0004, 32'h1001_0004, 1'b0, 1'b1, 5'd0,  32'h0001_4000, 32'h1001_0004};
    vecs[2] = '{32'h0040_0008, 32'h8C1F_0000, 32'h1001_FFFC, 1'b1, 1'b1, 5'd31, 32'h0002_FE00, 32'h1001_FFFC};
    vecs[3] = '{32'h0040_000C, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 1'b0, 5'd17, 32'h0003_2200, 32'h0000_0000};

    rst_n = 1'b0; retire = 1'b0; tx_ready = 1'b0;
    pc = '0; instr = '0; dm_addr = '0; reg_we = 1'b0; dm_en = 1'b0; reg_waddr = '0;
    #12;
    check("reset tx_valid", {31'b0, tx_valid}, 32'd0);
    check("reset tx_data", tx_data, 32'd0);
    check("reset tx_last", {31'b0, tx_last}, 32'd0);
    check("reset drop_count", {24'b0, drop_count}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Single records, seq 0..3, each into an empty FIFO with the FSM idle.
    tx_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      do_retire(vecs[k].pc, vecs[k].instr, vecs[k].dm_addr, vecs[k].reg_we, vecs[k].dm_en, vecs[k].waddr);
      check($sformatf("vec%0d valid at push edge", k), {31'b0, tx_valid}, 32'd0);
      check_record($sformatf("vec%0d", k), vecs[k].exp_hdr, vecs[k].pc, vecs[k].instr, vecs[k].exp_addr, w);
      check($sformatf("vec%0d latency", k), 32'(w), 32'd1);
      check($sformatf("vec%0d idle after", k), {31'b0, tx_valid}, 32'd0);
    end

    // Backpressure on the PC word, seq 4.
    do_retire(32'h0040_0000, 32'h2002_0005, 32'h0, 1'b1, 1'b0, 5'd2);
    tick();
    expect_word("bp hdr", 32'h0004_8400, 1'b0);
    tx_ready = 1'b0;
    repeat (5) begin
      tick();
      check("bp hold valid", {31'b0, tx_valid}, 32'd1);
      check("bp hold data", tx_data, 32'h0040_0000);
    end
    tx_ready = 1'b1;
    expect_word("bp pc", 32'h0040_0000, 1'b0);
    expect_word("bp instr", 32'h2002_0005, 1'b0);
    expect_word("bp addr", 32'h0, 1'b1);

    // Overflow: six retires (seq 5..10) with the link stalled; 9 and 10 drop.
    tx_ready = 1'b0;
    for (int i = 0; i < 6; i++) do_retire(32'h1000 + 32'(4 * i), 32'(i), 32'h0, 1'b0, 1'b0, 5'd0);
    check("ovf drop_count", {24'b0, drop_count}, 32'd2);
    for (int i = 0; i < 4; i++) begin
      check_record($sformatf("ovf drain%0d", i), 32'(5 + i) << 16, 32'h1000 + 32'(4 * i), 32'(i), 32'h0, w);
      check($sformatf("ovf drain%0d bubble", i), 32'(w), 32'd0);
    end
    check("ovf idle after drain", {31'b0, tx_valid}, 32'd0);
    do_retire(32'h5000, 32'h1, 32'h0, 1'b0, 1'b0, 5'd0);
    check_record("ovf flagged", 32'h000B_0100, 32'h5000, 32'h1, 32'h0, w);
    do_retire(32'h5004, 32'h2, 32'h0, 1'b0, 1'b0, 5'd0);
    check_record("ovf cleared", 32'h000C_0000, 32'h5004, 32'h2, 32'h0, w);

    // Full FIFO (seq 13..16), retire of seq 17 lands on the ADDR acceptance.
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) do_retire(32'h2000 + 32'(4 * i), 32'h100 + 32'(i), 32'h0, 1'b0, 1'b0, 5'd0);
    tx_ready = 1'b1;
    expect_word("full hdr", 32'h000D_0000, 1'b0);
    expect_word("full pc", 32'h2000, 1'b0);
    expect_word("full instr", 32'h100, 1'b0);
    set_retire(32'h3000, 32'h200, 32'h0, 1'b0, 1'b0, 5'd0);
    expect_word("full addr", 32'h0, 1'b1);
    retire = 1'b0;
    check("full no drop", {24'b0, drop_count}, 32'd2);
    for (int i = 1; i < 4; i++) begin
      check_record($sformatf("full rec%0d", i), 32'(13 + i) << 16, 32'h2000 + 32'(4 * i), 32'h100 + 32'(i), 32'h0, w);
      check($sformatf("full rec%0d bubble", i), 32'(w), 32'd0);
    end
    check_record("full pushed", 32'h0011_0000, 32'h3000, 32'h200, 32'h0, w);
    check("full pushed bubble", 32'(w), 32'd0);

    // Asynchronous reset while the INSTR word of seq 18 is presented.
    do_retire(32'h0040_0000, 32'h2002_0005, 32'h0, 1'b1, 1'b0, 5'd2);
    tick();
    expect_word("rst hdr", 32'h0012_8400, 1'b0);
    expect_word("rst pc", 32'h0040_0000, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rst tx_valid", {31'b0, tx_valid}, 32'd0);
    check("rst tx_data", tx_data, 32'd0);
    check("rst tx_last", {31'b0, tx_last}, 32'd0);
    check("rst drop_count", {24'b0, drop_count}, 32'd0);
    #3 rst_n = 1'b1;
    tick();
    do_retire(32'h0040_0000, 32'h2002_0005, 32'h0, 1'b1, 1'b0, 5'd2);
    check_record("rst after", 32'h0000_8400, 32'h0040_0000, 32'h2002_0005, 32'h0, w);

    // seq 1..65534 with the link stalled: FIFO keeps 1..4, drop_count saturates.
    tx_ready = 1'b0;
    set_retire(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
    repeat (65534) tick();
    retire = 1'b0;
    check("sat drop_count", {24'b0, drop_count}, 32'd255);
    for (int i = 0; i < 4; i++) begin
      check_record($sformatf("sat drain%0d", i), 32'(1 + i) << 16, 32'h0, 32'h0, 32'h0, w);
    end
    do_retire(32'h6000, 32'h3, 32'h0, 1'b0, 1'b0, 5'd0);
    check_record("wrap ffff", 32'hFFFF_0100, 32'h6000, 32'h3, 32'h0, w);
    do_retire(32'h6004, 32'h4, 32'h0, 1'b0, 1'b0, 5'd0);
    check_record("wrap 0000", 32'h0000_0000, 32'h6004, 32'h4, 32'h0, w);
    check("sat drop_count hold", {24'b0, drop_count}, 32'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trace_streamer.md
# trace_streamer

Hardware instruction-trace emitter for the single-cycle MIPS-subset CPU. Each cycle the CPU retires an instruction, the block captures pc, instruction word, register-write address and data-memory address into a small record FIFO. It then streams each record out as four 32-bit words over a valid/ready link. The block gives the simulation bench, or an off-chip logger, the same per-instruction trace without probing CPU internals hierarchically.

## Interface
Parameters:
- DEPTH, 4, record FIFO depth; power of two, ≥2.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- retire  in  1  one-cycle strobe: an instruction completed this cycle.
- pc  in  32  PC of the retiring instruction.
- instr  in  32  instruction word.
- reg_we  in  1  retiring instruction writes the register file.
- reg_waddr  in  5  register-file write address.
- dm_en  in  1  retiring instruction accesses data memory.
- dm_addr  in  32  data-memory address.
- tx_data  out  32  current stream word.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  downstream accepts the word when tx_valid && tx_ready.
- tx_last  out  1  current word is the last word of its record.
- drop_count  out  8  records dropped due to full FIFO; saturates at 255.

## Operation
- seq: 16-bit counter, incremented on every retire, including dropped ones; wraps 65535→0. A captured record holds seq as it was before the increment.
- Push: when retire=1 and the FIFO is not full, the record {seq, reg_we, dm_en, reg_waddr, ovf, pc, instr, dm_addr} is written.
- Drop: when retire=1 and the FIFO is full with no pop this cycle, the record is discarded, drop_count increments (saturating), and the sticky ovf_pending flag is set.
- ovf bit: the next successfully pushed record carries ovf=1, and that push clears ovf_pending. A gap in seq also reveals drops.
- Header word layout: [31:16] seq, [15] reg_we, [14] dm_en, [13:9] reg_waddr, [8] ovf, [7:0] 0.
- Stream word order: HDR, PC, INSTR, ADDR. ADDR is dm_addr, or 0 when dm_en=0. tx_last=1 only on ADDR.
- FSM states:
  - IDLE: tx_valid=0. Goes to HDR when the FIFO is non-empty.
  - HDR → PC → INSTR → ADDR: each advances only on tx_valid && tx_ready.
  - On ADDR acceptance the head record pops. The FSM goes to HDR if more records remain, otherwise to IDLE.
- tx_data and tx_valid are registered and driven from the FIFO head. tx_data is held stable while tx_valid && !tx_ready.

## Timing
- Reset values: tx_valid=0, tx_data=0, tx_last=0, drop_count=0, seq=0, ovf_pending=0, FSM=IDLE, FIFO empty.
- Latency: a retire at edge N into an empty FIFO with the FSM in IDLE gives tx_valid=1 with HDR after edge N+1.
- Throughput: one word per cycle when tx_ready=1 continuously; 4 cycles per record. Back-to-back records have no bubble.
- Simultaneous events:
  - Full FIFO, retire, and pop (ADDR accepted) in the same cycle: the push succeeds and nothing is dropped.
  - Empty FIFO, retire, and FSM in IDLE: the push occurs and HDR is presented next cycle.
- tx_valid, once high, stays high until the word is accepted. It never drops while tx_ready=0.
- Reset mid-record: everything returns to reset values immediately (asynchronous). The partial record is lost and no tx_last is emitted for it.
- seq wrap: the record after seq=0xFFFF carries seq=0x0000, with no other side effect.

## Structure
- Package trace_pkg:
  - FSM state enum (IDLE, HDR, PC, INSTR, ADDR).
  - Header bit-position constants.
  - Packed record struct (120 bits).
- Sub-module trace_fifo: synchronous register FIFO of trace_pkg records.
  - Ports: push, pop, din, dout (head), full, empty.
  - Pointers are log2(DEPTH)+1 bits wide so full/empty are decoded from the wrap bit.
- trace_streamer holds seq, drop/ovf logic, the FSM and the output registers.

## Test plan
- Single record:
  - Stimulus: retire with pc=0x00400000, instr=0x20020005, reg_we=1, reg_waddr=2, dm_en=0; tx_ready=1.
  - Response: words 0x00008400, 0x00400000, 0x20020005, 0x00000000, tx_last on the 4th word only, tx_valid rising one cycle after retire.
- Backpressure:
  - Stimulus: tx_ready=0 for 5 cycles mid-PC word.
  - Response: tx_data stays 0x00400000 with tx_valid=1 throughout; the stream resumes in order once tx_ready=1.
- Overflow (DEPTH=4):
  - Stimulus: tx_ready=0 while 6 retires occur.
  - Response: 4 records stored and drop_count=2. After draining, the next retire's header has ovf=1 and seq=6; the following header has ovf=0.
- Full plus simultaneous pop and push:
  - Stimulus: FIFO full, ADDR accepted in the same cycle as a retire.
  - Response: drop_count unchanged and the new record is streamed later.
- Wrap and saturation:
  - Force seq=0xFFFF, then retire twice; the headers carry 0xFFFF and 0x0000.
  - After 300 drops, drop_count holds at 255.
- Reset mid-stream:
  - Stimulus: assert rst_n=0 during the INSTR word.
  - Response: tx_valid=0 immediately. After release, a retire yields a header with seq=0.
